// File: rtl/pulse_monitor.sv
`default_nettype none
// ============================================================================
// Module      : pulse_monitor
// Description : Receive-side checker for a periodic low-pulse waveform.
//               Measures falling-edge-to-falling-edge period and low width,
//               compares them with the expected values, tracks lock and
//               flags mismatches and loss of signal.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_monitor #(
    parameter int W          = 16,
    parameter int PERIODO    = 500,
    parameter int LARGURA    = 70,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 3,
    parameter int TIMEOUT    = 1023
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Entrada,
    output logic [W-1:0] Periodo,
    output logic [W-1:0] Largura,
    output logic         Valido,
    output logic         Travado,
    output logic         Erro
);

    // Match counter only needs to reach LOCK_COUNT
    localparam int c_MW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

    localparam logic [W-1:0]    c_PER     = W'(PERIODO);
    localparam logic [W-1:0]    c_LAR     = W'(LARGURA);
    localparam logic [W-1:0]    c_TOL     = W'(TOL);
    localparam logic [W-1:0]    c_TIMEOUT = W'(TIMEOUT);
    localparam logic [c_MW-1:0] c_LOCK    = c_MW'(LOCK_COUNT);

    localparam logic [1:0] c_BUSCA     = 2'd0;
    localparam logic [1:0] c_MED_BAIXO = 2'd1;
    localparam logic [1:0] c_MED_ALTO  = 2'd2;

    logic            r_s1;
    logic            r_s2;
    logic            r_s3;
    logic [1:0]      r_state;
    logic [W-1:0]    r_cnt;
    logic [W-1:0]    r_larg;
    logic [c_MW-1:0] r_match;

    logic            w_fall;
    logic            w_rise;
    logic            w_timeout;
    logic            w_ok;
    logic [c_MW-1:0] w_match_inc;

    // Distance between two unsigned values without wrap-around
    function automatic logic [W-1:0] f_absdiff(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign w_fall      = r_s3 & ~r_s2;
    assign w_rise      = ~r_s3 & r_s2;
    assign w_timeout   = (r_state != c_BUSCA) && (r_cnt == c_TIMEOUT) && !w_fall && !w_rise;
    assign w_ok        = (f_absdiff(r_cnt, c_PER) <= c_TOL) && (f_absdiff(r_larg, c_LAR) <= c_TOL);
    assign w_match_inc = (r_match >= c_LOCK) ? c_LOCK : (r_match + 1'b1);

    // Two-flop synchronizer plus one delay stage for edge detection; idles high
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= Entrada;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Cycles elapsed since the last falling edge; parked at zero while hunting
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (w_fall) begin
            r_cnt <= W'(1);
        end else if (r_state == c_MED_BAIXO || r_state == c_MED_ALTO) begin
            r_cnt <= (r_cnt == {W{1'b1}}) ? r_cnt : (r_cnt + 1'b1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Measurement FSM, match tracking and registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= c_BUSCA;
            r_larg  <= '0;
            r_match <= '0;
            Periodo <= '0;
            Largura <= '0;
            Valido  <= 1'b0;
            Travado <= 1'b0;
            Erro    <= 1'b0;
        end else begin
            Valido <= 1'b0;
            Erro   <= 1'b0;
            if (w_timeout) begin
                // Signal lost: drop lock and hunt for the next falling edge
                Erro    <= 1'b1;
                Travado <= 1'b0;
                r_match <= '0;
                r_state <= c_BUSCA;
            end else begin
                case (r_state)
                    c_BUSCA: begin
                        if (w_fall) begin
                            r_state <= c_MED_BAIXO;
                        end
                    end
                    c_MED_BAIXO: begin
                        if (w_rise) begin
                            r_larg  <= r_cnt;
                            r_state <= c_MED_ALTO;
                        end
                    end
                    c_MED_ALTO: begin
                        if (w_fall) begin
                            // Period complete; the next one already started
                            Periodo <= r_cnt;
                            Largura <= r_larg;
                            Valido  <= 1'b1;
                            r_state <= c_MED_BAIXO;
                            if (w_ok) begin
                                r_match <= w_match_inc;
                                Travado <= (w_match_inc == c_LOCK);
                            end else begin
                                Erro    <= 1'b1;
                                r_match <= '0;
                                Travado <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= c_BUSCA;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
